// File: rtl/stream_unstacker_pkg.sv
// Shared types and default widths for the stream unstacker
// (wide word -> sequence of narrow slices).
package stream_unstacker_pkg;

    localparam int DEF_IN_WIDTH  = 128;
    localparam int DEF_OUT_WIDTH = 32;

    typedef enum logic {
        ORDER_MSB_FIRST = 1'b0,
        ORDER_LSB_FIRST = 1'b1
    } order_e;

endpackage

// File: rtl/stream_unstacker.sv
// Splits each accepted IN_WIDTH word into IN_WIDTH/OUT_WIDTH slices, MSB- or LSB-first.
// Optional last_o output is enabled by defining STREAM_UNSTACKER_LAST_EN.
module stream_unstacker
    import stream_unstacker_pkg::*;
#(
    parameter int IN_WIDTH  = DEF_IN_WIDTH,
    parameter int OUT_WIDTH = DEF_OUT_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clr_i,
    input  logic                 enable_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [IN_WIDTH-1:0]  word_i,
    input  logic                 order_i,
`ifdef STREAM_UNSTACKER_LAST_EN
    output logic                 last_o,
`endif
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [OUT_WIDTH-1:0] word_o
);

    localparam int RATIO = IN_WIDTH / OUT_WIDTH;
    localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATIO - 1);

    if ((IN_WIDTH < OUT_WIDTH) || ((IN_WIDTH % OUT_WIDTH) != 0)) begin : g_bad_widths
        $error("stream_unstacker: IN_WIDTH must be a non-zero multiple of OUT_WIDTH");
    end

    logic [IN_WIDTH-1:0]  r_data;
    logic                 r_filled;
    logic [CNT_W-1:0]     r_cnt;
    order_e               r_order;

    logic                 w_last;
    logic                 w_load;
    logic                 w_emit;
    logic [CNT_W-1:0]     w_k;
    logic [OUT_WIDTH-1:0] w_slice;

    assign w_last  = (r_cnt == LAST_CNT);
    // Gated by rst_ni so ready_o cannot advertise space while reset is held.
    assign valid_o = rst_ni & enable_i & r_filled;
    assign ready_o = rst_ni & enable_i & (~r_filled | (ready_i & w_last));
    assign w_load  = valid_i & ready_o;
    assign w_emit  = valid_o & ready_i;

`ifdef STREAM_UNSTACKER_LAST_EN
    assign last_o = valid_o & w_last;
`endif

    assign w_k = (r_order == ORDER_LSB_FIRST) ? r_cnt : (LAST_CNT - r_cnt);

    always_comb begin
        w_slice = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (CNT_W'(i) == w_k) begin
                w_slice = r_data[i*OUT_WIDTH +: OUT_WIDTH];
            end
        end
    end

    assign word_o = r_filled ? w_slice : '0;

    // A load in the last-slice cycle overrides the drain, keeping the stream bubble-free.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_data   <= '0;
            r_filled <= 1'b0;
            r_cnt    <= '0;
            r_order  <= ORDER_MSB_FIRST;
        end else if (clr_i) begin
            r_data   <= '0;
            r_filled <= 1'b0;
            r_cnt    <= '0;
            r_order  <= ORDER_MSB_FIRST;
        end else if (enable_i) begin
            if (w_load) begin
                r_data   <= word_i;
                r_order  <= order_e'(order_i);
                r_cnt    <= '0;
                r_filled <= 1'b1;
            end else if (w_emit) begin
                if (w_last) begin
                    r_filled <= 1'b0;
                    r_cnt    <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_stream_unstacker.sv
// Bench for stream_unstacker: queue-based slice model checked every cycle, plus
// directed literal expectations for MSB/LSB order, streaming, stalls, clear and reset.
module tb_stream_unstacker;

    localparam int IW = 128;
    localparam int OW = 32;
    localparam int R  = IW / OW;
    localparam logic [127:0] W0 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] W1 = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    localparam logic [127:0] W2 = 128'h0F0F0F0F_A5A5A5A5_5A5A5A5A_F0F0F0F0;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr = 1'b0;
    logic          enable = 1'b1;
    logic          valid_i = 1'b0;
    logic          ready_o;
    logic [IW-1:0] word_i = '0;
    logic          order_i = 1'b0;
    logic          valid_o;
    logic          ready_i = 1'b1;
    logic [OW-1:0] word_o;

    logic          v2 = 1'b0;
    logic          r2_o;
    logic [63:0]   w2 = '0;
    logic          v2_o;
    logic [15:0]   w2_o;
    logic          last2;

    int n_cmp = 0;
    int n_bad = 0;

    logic [OW-1:0] exp_q[$];

    always #5 clk = ~clk;

    stream_unstacker #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .enable_i(enable),
        .valid_i(valid_i), .ready_o(ready_o), .word_i(word_i), .order_i(order_i),
`ifdef STREAM_UNSTACKER_LAST_EN
        .last_o(),
`endif
        .valid_o(valid_o), .ready_i(ready_i), .word_o(word_o)
    );

    stream_unstacker #(.IN_WIDTH(64), .OUT_WIDTH(16)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .enable_i(enable),
        .valid_i(v2), .ready_o(r2_o), .word_i(w2), .order_i(1'b0),
`ifdef STREAM_UNSTACKER_LAST_EN
        .last_o(last2),
`endif
        .valid_o(v2_o), .ready_i(1'b1), .word_o(w2_o)
    );
`ifndef STREAM_UNSTACKER_LAST_EN
    assign last2 = 1'b0;
`endif

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: pending slices of the buffered word, in emission order.
    always @(negedge clk) begin
        logic          e_valid, e_ready;
        logic [OW-1:0] e_word;
        if (!rst_n) begin
            exp_q.delete();
            check("rst_valid", {127'b0, valid_o}, 128'd0);
            check("rst_ready", {127'b0, ready_o}, 128'd0);
            check("rst_word", {96'b0, word_o}, 128'd0);
        end else begin
            e_valid = enable && (exp_q.size() > 0);
            e_ready = enable && (exp_q.size() == 0 || (ready_i && exp_q.size() == 1));
            e_word  = (exp_q.size() > 0) ? exp_q[0] : '0;
            check("model_valid", {127'b0, valid_o}, {127'b0, e_valid});
            check("model_ready", {127'b0, ready_o}, {127'b0, e_ready});
            check("model_word", {96'b0, word_o}, {96'b0, e_word});
            if (clr) begin
                exp_q.delete();
            end else begin
                if (e_valid && ready_i) void'(exp_q.pop_front());
                if (valid_i && e_ready) begin
                    for (int s = 0; s < R; s++) begin
                        int sh;
                        sh = order_i ? s : (R - 1 - s);
                        exp_q.push_back(OW'(word_i >> (sh * OW)));
                    end
                end
            end
        end
    end

    task automatic send(input logic [IW-1:0] w, input logic o);
        bit ok;
        ok = 0;
        valid_i = 1'b1;
        word_i  = w;
        order_i = o;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            if (ready_o) ok = 1;
        end
        step();
        valid_i = 1'b0;
        check("send_accepted", {127'b0, ok}, 128'd1);
    endtask

    task automatic expect_slices(input string name, input logic [127:0] w, input logic o);
        for (int i = 0; i < R; i++) begin
            int sh;
            logic [OW-1:0] lit;
            sh  = o ? i : (R - 1 - i);
            lit = OW'(w >> (sh * OW));
            @(negedge clk);
            check({name, "_valid"}, {127'b0, valid_o}, 128'd1);
            check({name, "_word"}, {96'b0, word_o}, {96'b0, lit});
            step();
        end
        @(negedge clk);
        check({name, "_idle"}, {127'b0, valid_o}, 128'd0);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with enable high: ready_o must stay low.
        repeat (3) @(negedge clk);
        check("reset_ready_lit", {127'b0, ready_o}, 128'd0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_ready", {127'b0, ready_o}, 128'd1);
        step();

        // MSB-first, hand-computed literals
        send(W0, 1'b0);
        @(negedge clk); check("msb_s0", {96'b0, word_o}, 128'h00112233); step();
        @(negedge clk); check("msb_s1", {96'b0, word_o}, 128'h44556677); step();
        @(negedge clk); check("msb_s2", {96'b0, word_o}, 128'h8899AABB); step();
        @(negedge clk); check("msb_s3", {96'b0, word_o}, 128'hCCDDEEFF); step();
        @(negedge clk); check("msb_done", {127'b0, valid_o}, 128'd0); step();

        // LSB-first
        send(W0, 1'b1);
        @(negedge clk); check("lsb_s0", {96'b0, word_o}, 128'hCCDDEEFF); step();
        @(negedge clk); check("lsb_s1", {96'b0, word_o}, 128'h8899AABB); step();
        @(negedge clk); check("lsb_s2", {96'b0, word_o}, 128'h44556677); step();
        @(negedge clk); check("lsb_s3", {96'b0, word_o}, 128'h00112233); step();
        @(negedge clk); check("lsb_done", {127'b0, valid_o}, 128'd0); step();

        // Back-to-back: three words offered continuously
        valid_i = 1'b1; word_i = W0; order_i = 1'b0;
        @(negedge clk);
        check("b2b_first_ready", {127'b0, ready_o}, 128'd1);
        step();
        word_i = W1; order_i = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("b2b_valid", {127'b0, valid_o}, 128'd1);
            check("b2b_ready", {127'b0, ready_o}, {127'b0, (i % 4 == 3)});
            step();
            if (i == 3) begin word_i = W2; order_i = 1'b0; end
            if (i == 7) valid_i = 1'b0;
        end
        @(negedge clk); check("b2b_done", {127'b0, valid_o}, 128'd0); step();

        // Backpressure then freeze, holding slice 1
        send(W0, 1'b0);
        @(negedge clk); check("bp_s0", {96'b0, word_o}, 128'h00112233); step();
        ready_i = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("bp_hold_word", {96'b0, word_o}, 128'h44556677);
            check("bp_hold_valid", {127'b0, valid_o}, 128'd1);
            step();
        end
        enable = 1'b0; ready_i = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("frz_word", {96'b0, word_o}, 128'h44556677);
            check("frz_valid", {127'b0, valid_o}, 128'd0);
            check("frz_ready", {127'b0, ready_o}, 128'd0);
            step();
        end
        enable = 1'b1;
        @(negedge clk); check("bp_s1", {96'b0, word_o}, 128'h44556677); step();
        @(negedge clk); check("bp_s2", {96'b0, word_o}, 128'h8899AABB); step();
        @(negedge clk); check("bp_s3", {96'b0, word_o}, 128'hCCDDEEFF); step();
        @(negedge clk); check("bp_done", {127'b0, valid_o}, 128'd0); step();

        // Clear mid-word
        send(W0, 1'b0);
        step(); step();
        clr = 1'b1;
        @(negedge clk); check("clr_still_s2", {96'b0, word_o}, 128'h8899AABB); step();
        clr = 1'b0;
        @(negedge clk);
        check("clr_valid", {127'b0, valid_o}, 128'd0);
        check("clr_word", {96'b0, word_o}, 128'd0);
        step();
        send(W1, 1'b0);
        expect_slices("after_clr", W1, 1'b0);

        // Reset mid-word (asserted between edges)
        send(W0, 1'b0);
        step(); step();
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_valid", {127'b0, valid_o}, 128'd0);
        check("rst_mid_word", {96'b0, word_o}, 128'd0);
        step();
        rst_n = 1'b1;
        step();
        send(W0, 1'b1);
        @(negedge clk); check("after_rst_s0", {96'b0, word_o}, 128'hCCDDEEFF); step();
        step(); step(); step();
        @(negedge clk); check("after_rst_done", {127'b0, valid_o}, 128'd0); step();

        // 64/16 instance: four slices, last_o only on the fourth
        v2 = 1'b1; w2 = 64'h1111_2222_3333_4444;
        @(negedge clk); check("cfg2_ready", {127'b0, r2_o}, 128'd1);
        step();
        v2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            logic [15:0] lit;
            logic [63:0] tmp;
            tmp = 64'h1111_2222_3333_4444;
            lit = 16'(tmp >> ((3 - i) * 16));
            @(negedge clk);
            check("cfg2_valid", {127'b0, v2_o}, 128'd1);
            check("cfg2_word", {112'b0, w2_o}, {112'b0, lit});
`ifdef STREAM_UNSTACKER_LAST_EN
            check("cfg2_last", {127'b0, last2}, {127'b0, (i == 3)});
`endif
            step();
        end
        @(negedge clk); check("cfg2_done", {127'b0, v2_o}, 128'd0); step();

        repeat (2) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
